// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters A/B/index pins, decodes
// the Gray sequence into step/dir commands, flags illegal jumps and issues index loads.
module quad_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       idx_in,
  input  logic       idx_en,
  input  logic [3:0] home_value,
  input  logic       err_clr,
  output logic       step,
  output logic       dir,
  output logic       load,
  output logic [3:0] load_data,
  output logic       err
);

  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
  // A pin held through reset needs FILTER_LEN+2 clocks to reach the filter output and one
  // more clock before the decoder compares it, so gating covers that whole window.
  localparam logic [4:0] ARM_LEN   = 5'(FILTER_LEN + 3);

  logic [2:0] pins;
  logic [2:0] filt;

  assign pins = {idx_in, b_in, a_in};

  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    logic       sync1;
    logic       sync2;
    logic       filt_q;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        filt_q <= 1'b0;
        cnt    <= 4'd0;
      end else begin
        sync1 <= pins[gi];
        sync2 <= sync1;
        if (sync2 == filt_q) begin
          cnt <= 4'd0;
        end else if (cnt == FILT_LAST) begin
          filt_q <= sync2;
          cnt    <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end

    assign filt[gi] = filt_q;
  end

  logic [1:0] cur_ab;
  logic [1:0] prev_ab;
  logic       prev_idx;
  logic [4:0] arm_cnt;
  logic       armed;
  logic       fwd;
  logic       rev;
  logic       illegal;
  logic       load_hit;

  assign cur_ab   = {filt[0], filt[1]};
  assign armed    = (arm_cnt == ARM_LEN);
  assign load_hit = armed & idx_en & filt[2] & ~prev_idx;

  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    illegal = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd     = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev     = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab   <= 2'b00;
      prev_idx  <= 1'b0;
      arm_cnt   <= 5'd0;
      step      <= 1'b0;
      dir       <= 1'b0;
      load      <= 1'b0;
      load_data <= 4'h0;
      err       <= 1'b0;
    end else begin
      prev_ab  <= cur_ab;
      prev_idx <= filt[2];
      if (!armed) begin
        arm_cnt <= arm_cnt + 5'd1;
      end
      // An index load re-homes the counter, so a coincident step is dropped.
      step <= armed & (fwd | rev) & ~load_hit;
      load <= load_hit;
      if (load_hit) begin
        load_data <= home_value;
      end
      if (armed & (fwd | rev)) begin
        dir <= fwd;
      end
      if (armed & illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized and directed bench for quad_decoder, checked every cycle against a
// history-window / Gray-position model of the decoder.
module tb_quad_decoder;

  localparam int FL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       idx_in = 1'b0;
  logic       idx_en = 1'b0;
  logic [3:0] home_value = 4'h0;
  logic       err_clr = 1'b0;
  logic       step;
  logic       dir;
  logic       load;
  logic [3:0] load_data;
  logic       err;

  quad_decoder #(.FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in), .idx_en(idx_en),
    .home_value(home_value), .err_clr(err_clr), .step(step), .dir(dir), .load(load),
    .load_data(load_data), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int step_cnt = 0;
  int load_cnt = 0;
  int last_step_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [2:0] smp [0:FL+1];
  logic [2:0] f = 3'b000;
  logic [2:0] f_prev = 3'b000;
  int         n_edges = 0;
  logic       exp_step = 1'b0;
  logic       exp_dir = 1'b0;
  logic       exp_load = 1'b0;
  logic [3:0] exp_load_data = 4'h0;
  logic       exp_err = 1'b0;

  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= FL + 1; k++) smp[k] = 3'b000;
    f = 3'b000;
    f_prev = 3'b000;
    n_edges = 0;
    exp_step = 1'b0;
    exp_dir = 1'b0;
    exp_load = 1'b0;
    exp_load_data = 4'h0;
    exp_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] nf;
    int d;
    bit armed, moved, lq, all_diff;
    for (int k = FL + 1; k >= 1; k--) smp[k] = smp[k-1];
    smp[0] = {idx_in, a_in, b_in};
    nf = f;
    for (int bi = 0; bi < 3; bi++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= FL + 1; k++) if (smp[k][bi] == f[bi]) all_diff = 1'b0;
      if (all_diff) nf[bi] = ~f[bi];
    end
    if (n_edges < 1000) n_edges++;
    armed = (n_edges >= FL + 4);
    d = (gray_pos(f[1:0]) - gray_pos(f_prev[1:0]) + 4) % 4;
    moved = armed && (d == 1 || d == 3);
    lq = armed && idx_en && f[2] && !f_prev[2];
    exp_load = lq;
    if (lq) exp_load_data = home_value;
    exp_step = moved && !lq;
    if (moved) exp_dir = (d == 1);
    if (armed && d == 2) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
    f_prev = f;
    f = nf;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_val("step", step, exp_step);
      check_val("dir", dir, exp_dir);
      check_val("load", load, exp_load);
      check_val("load_data", load_data, exp_load_data);
      check_val("err", err, exp_err);
      if (step === 1'b1) begin
        step_cnt++;
        last_step_cyc = cyc;
      end
      if (load === 1'b1) load_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic move(input logic na, input logic nb, input int exp_delta, input logic exp_d,
                      input string nm);
    int s0, t0;
    s0 = step_cnt;
    t0 = cyc;
    a_in = na;
    b_in = nb;
    tick(10);
    check_val({nm, "_steps"}, step_cnt - s0, exp_delta);
    if (exp_delta == 1) check_val({nm, "_latency"}, last_step_cyc - t0, 6);
    check_val({nm, "_dir"}, dir, exp_d);
    $display("move %s: ab=%b%b steps=%0d dir=%b", nm, na, nb, step_cnt - s0, dir);
  endtask

  initial begin
    int s0, hold;
    // Reset and arm with both channels high
    a_in = 1'b1;
    b_in = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    check_val("arm_steps", step_cnt, 0);
    check_val("arm_err", err, 0);
    check_val("arm_dir", dir, 0);
    check_val("arm_load_data", load_data, 0);
    $display("arm: steps=%0d err=%b dir=%b", step_cnt, err, dir);

    move(1'b1, 1'b0, 1, 1'b1, "pre_up1");
    move(1'b0, 1'b0, 1, 1'b1, "pre_up2");
    move(1'b0, 1'b1, 1, 1'b1, "up1");
    move(1'b1, 1'b1, 1, 1'b1, "up2");
    move(1'b1, 1'b0, 1, 1'b1, "up3");
    move(1'b0, 1'b0, 1, 1'b1, "up4");
    move(1'b1, 1'b0, 1, 1'b0, "down1");
    move(1'b1, 1'b1, 1, 1'b0, "down2");
    move(1'b1, 1'b0, 1, 1'b1, "reverse");

    // Glitches on A from AB=10
    s0 = step_cnt;
    a_in = 1'b0; tick(2); a_in = 1'b1; tick(10);
    check_val("glitch2_steps", step_cnt - s0, 0);
    check_val("glitch2_dir", dir, 1);
    $display("glitch2: steps=%0d", step_cnt - s0);
    s0 = step_cnt;
    a_in = 1'b0; tick(3); a_in = 1'b1; tick(12);
    check_val("glitch3_steps", step_cnt - s0, 2);
    check_val("glitch3_dir", dir, 0);
    $display("glitch3: steps=%0d dir=%b", step_cnt - s0, dir);

    // Illegal transitions and err_clr priority
    s0 = step_cnt;
    a_in = 1'b0; b_in = 1'b1; tick(10);
    check_val("illegal_err", err, 1);
    check_val("illegal_steps", step_cnt - s0, 0);
    a_in = 1'b1; b_in = 1'b0; tick(5);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check_val("set_beats_clr", err, 1);
    tick(4);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check_val("lone_clr", err, 0);
    check_val("illegal_steps2", step_cnt - s0, 0);
    $display("illegal: err=%b steps=%0d", err, step_cnt - s0);

    // Index coincident with a valid A edge (10 -> 00, up)
    home_value = 4'hA;
    idx_en = 1'b1;
    idx_in = 1'b1; a_in = 1'b0; tick(6);
    check_val("idx_load", load, 1);
    check_val("idx_step", step, 0);
    check_val("idx_load_data", load_data, 4'hA);
    check_val("idx_dir", dir, 1);
    $display("index: load=%b step=%b load_data=%h", load, step, load_data);
    tick(4); idx_in = 1'b0; tick(10);
    home_value = 4'h5;
    idx_en = 1'b0;
    idx_in = 1'b1; a_in = 1'b1; tick(6);
    check_val("noidx_load", load, 0);
    check_val("noidx_step", step, 1);
    check_val("noidx_load_data", load_data, 4'hA);
    check_val("noidx_dir", dir, 0);
    $display("index disabled: load=%b step=%b load_data=%h", load, step, load_data);
    tick(4); idx_in = 1'b0; tick(10);

    // Reset while a step is in flight
    s0 = step_cnt;
    b_in = 1'b1; tick(3);
    rst = 1'b1; tick(2);
    check_val("midrst_dir", dir, 0);
    rst = 1'b0; tick(15);
    check_val("midrst_steps", step_cnt - s0, 0);
    $display("mid reset: steps=%0d", step_cnt - s0);

    // Random phase
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        a_in = 1'($urandom_range(0, 1));
        b_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
        if ($urandom_range(0, 3) == 0) idx_in = ~idx_in;
        idx_en = 1'($urandom_range(0, 1));
        home_value = 4'($urandom_range(0, 15));
      end
      hold--;
      err_clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    err_clr = 1'b0;
    tick(2);
    $display("random: steps=%0d loads=%0d", step_cnt, load_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
